// File: rtl/rggen_apb_regfile_pkg.sv
// Shared types for the APB register file: field access modes and
// the transfer state machine encoding.
package rggen_apb_regfile_pkg;

  typedef enum logic [1:0] {
    RGGEN_RW  = 2'd0,
    RGGEN_RO  = 2'd1,
    RGGEN_W1C = 2'd2,
    RGGEN_RC  = 2'd3
  } rggen_field_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } rggen_apb_regfile_state_e;

endpackage

// File: rtl/rggen_apb_regfile_field.sv
// One register field; storage and update rule depend on MODE.
// RO fields hold no state and forward the hardware value.
module rggen_apb_regfile_field
  import rggen_apb_regfile_pkg::*;
#(
  parameter int                WIDTH = 8,
  parameter rggen_field_mode_e MODE  = RGGEN_RW,
  parameter logic [WIDTH-1:0]  INIT  = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_mask,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rclr,
  input  logic [WIDTH-1:0] i_set,
  input  logic [WIDTH-1:0] i_ro,
  output logic [WIDTH-1:0] o_value
);

  // Not every mode consumes every input.
  logic unused_in;
  assign unused_in = ^{i_clk, i_rst, i_we, i_mask,
                       i_wdata, i_rclr, i_set, i_ro};

  if (MODE == RGGEN_RO) begin : g_ro
    assign o_value = i_ro;
  end else begin : g_store
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Hardware set is ORed in last so it wins over any clear.
    always_comb begin
      value_d = value_q;
      unique case (MODE)
        RGGEN_RW: begin
          if (i_we) begin
            value_d = (value_q & ~i_mask) | (i_wdata & i_mask);
          end
        end
        RGGEN_W1C: begin
          if (i_we) begin
            value_d = value_q & ~(i_wdata & i_mask);
          end
          value_d = value_d | i_set;
        end
        RGGEN_RC: begin
          if (i_rclr) begin
            value_d = '0;
          end
          value_d = value_d | i_set;
        end
        default: value_d = value_q;
      endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        value_q <= INIT;
      end else begin
        value_q <= value_d;
      end
    end

    assign o_value = value_q;
  end

endmodule

// File: rtl/rggen_apb_register_file.sv
// APB slave over an array of identical multi-field registers with
// wait states, byte strobes and an out-of-range error response.
module rggen_apb_register_file
  import rggen_apb_regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int DATA_WIDTH    = 64,
  parameter int REGISTERS     = 8,
  parameter int FIELD_WIDTH   = 8,
  parameter logic [2*(DATA_WIDTH/FIELD_WIDTH)-1:0] FIELD_MODE
    = 16'hE4E4,
  parameter logic [DATA_WIDTH-1:0] INITIAL_VALUE = '0,
  parameter int WAIT_STATES   = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_psel,
  input  logic                     i_penable,
  input  logic                     i_pwrite,
  input  logic [ADDRESS_WIDTH-1:0] i_paddr,
  input  logic [BUS_WIDTH-1:0]     i_pwdata,
  input  logic [BUS_WIDTH/8-1:0]   i_pstrb,
  output logic                     o_pready,
  output logic [BUS_WIDTH-1:0]     o_prdata,
  output logic                     o_pslverr,
  output logic [REGISTERS-1:0][DATA_WIDTH-1:0] o_value,
  input  logic [REGISTERS-1:0][DATA_WIDTH-1:0] i_ro_value,
  input  logic [REGISTERS-1:0][DATA_WIDTH-1:0] i_set
);

  localparam int BYTES_PER_WORD = BUS_WIDTH / 8;
  localparam int BYTES_PER_REG  = DATA_WIDTH / 8;
  localparam int WORDS          = DATA_WIDTH / BUS_WIDTH;
  localparam int FIELDS         = DATA_WIDTH / FIELD_WIDTH;
  localparam int LIMIT          = REGISTERS * BYTES_PER_REG;
  localparam int CNT_W =
    (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  rggen_apb_regfile_state_e state_q;
  rggen_apb_regfile_state_e state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic [BUS_WIDTH-1:0] prdata_q;
  logic [BUS_WIDTH-1:0] prdata_d;
  logic                 pslverr_q;
  logic                 pslverr_d;

  logic [31:0]          addr;
  logic [31:0]          reg_idx;
  logic [31:0]          word_idx;
  logic                 err;
  logic [BUS_WIDTH-1:0] rd_word;
  logic [BUS_WIDTH-1:0] wmask;
  logic                 wr_go;
  logic                 rd_go;

  assign addr     = 32'(i_paddr);
  assign reg_idx  = addr / 32'(BYTES_PER_REG);
  assign word_idx = (addr % 32'(BYTES_PER_REG))
                    / 32'(BYTES_PER_WORD);
  assign err      = addr >= 32'(LIMIT);

  always_comb begin
    rd_word = '0;
    for (int r = 0; r < REGISTERS; r++) begin
      for (int w = 0; w < WORDS; w++) begin
        if (reg_idx == 32'(r) && word_idx == 32'(w)) begin
          rd_word = o_value[r][w*BUS_WIDTH +: BUS_WIDTH];
        end
      end
    end
  end

  always_comb begin
    wmask = '0;
    for (int b = 0; b < BYTES_PER_WORD; b++) begin
      wmask[8*b +: 8] = {8{i_pstrb[b]}};
    end
  end

  // Side effects commit on the edge that ends DONE.
  assign wr_go = (state_q == ST_DONE) && i_pwrite && !err;
  assign rd_go = (state_q == ST_DONE) && !i_pwrite && !err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_psel && !i_penable) begin
          if (WAIT_STATES == 0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (!i_psel) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Response is captured from pre-commit values on DONE entry.
    prdata_d  = '0;
    pslverr_d = 1'b0;
    if (state_d == ST_DONE) begin
      pslverr_d = err;
      prdata_d  = err ? '0 : rd_word;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign o_pready  = (state_q == ST_DONE);
  assign o_prdata  = prdata_q;
  assign o_pslverr = pslverr_q;

  for (genvar r = 0; r < REGISTERS; r++) begin : g_reg
    for (genvar f = 0; f < FIELDS; f++) begin : g_field
      localparam int LSB  = f * FIELD_WIDTH;
      localparam int WORD = LSB / BUS_WIDTH;
      localparam int OFS  = LSB % BUS_WIDTH;

      logic hit;
      assign hit = (reg_idx == 32'(r))
                && (word_idx == 32'(WORD));

      rggen_apb_regfile_field #(
        .WIDTH (FIELD_WIDTH),
        .MODE  (rggen_field_mode_e'(FIELD_MODE[2*f +: 2])),
        .INIT  (INITIAL_VALUE[LSB +: FIELD_WIDTH])
      ) u_field (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (wr_go & hit),
        .i_mask  (wmask[OFS +: FIELD_WIDTH]),
        .i_wdata (i_pwdata[OFS +: FIELD_WIDTH]),
        .i_rclr  (rd_go & hit),
        .i_set   (i_set[r][LSB +: FIELD_WIDTH]),
        .i_ro    (i_ro_value[r][LSB +: FIELD_WIDTH]),
        .o_value (o_value[r][LSB +: FIELD_WIDTH])
      );
    end
  end

endmodule

// File: tb/tb_rggen_apb_register_file.sv
// Bench for the APB register file: zero-wait and two-wait instances
// checked every cycle against a per-bit behavioural model.
module tb_rggen_apb_register_file;

  logic clk;
  logic rst [2];
  logic psel [2];
  logic penable [2];
  logic pwrite [2];
  logic [7:0] paddr [2];
  logic [31:0] pwdata [2];
  logic [3:0] pstrb [2];
  logic ready [2];
  logic [31:0] prdata [2];
  logic slverr [2];
  logic [7:0][63:0] ov [2];
  logic [7:0][63:0] ro_v [2];
  logic [7:0][63:0] set_v [2];

  int n_chk = 0;
  int n_pass = 0;

  rggen_apb_register_file u_d0 (
    .i_clk(clk), .i_rst(rst[0]),
    .i_psel(psel[0]), .i_penable(penable[0]),
    .i_pwrite(pwrite[0]), .i_paddr(paddr[0]),
    .i_pwdata(pwdata[0]), .i_pstrb(pstrb[0]),
    .o_pready(ready[0]), .o_prdata(prdata[0]),
    .o_pslverr(slverr[0]), .o_value(ov[0]),
    .i_ro_value(ro_v[0]), .i_set(set_v[0])
  );

  rggen_apb_register_file #(.WAIT_STATES(2)) u_d2 (
    .i_clk(clk), .i_rst(rst[1]),
    .i_psel(psel[1]), .i_penable(penable[1]),
    .i_pwrite(pwrite[1]), .i_paddr(paddr[1]),
    .i_pwdata(pwdata[1]), .i_pstrb(pstrb[1]),
    .o_pready(ready[1]), .o_prdata(prdata[1]),
    .o_pslverr(slverr[1]), .o_value(ov[1]),
    .i_ro_value(ro_v[1]), .i_set(set_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, got, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] rw_m, ro_m, w1c_m, rc_m;
  logic [63:0] e_val [2][8];
  logic e_ready [2];
  logic e_err [2];
  logic busy [2];
  logic [31:0] e_rdata [2];
  int acc [2];

  function automatic int wsof(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  function automatic logic [31:0] mread(input int i, input int r,
                                        input int w);
    logic [63:0] v;
    v = (e_val[i][r] & ~ro_m) | (ro_v[i][r] & ro_m);
    return v[w*32 +: 32];
  endfunction

  task automatic mreset(input int i);
    for (int k = 0; k < 8; k++) e_val[i][k] = '0;
    e_ready[i] = 1'b0;
    e_err[i] = 1'b0;
    e_rdata[i] = '0;
    busy[i] = 1'b0;
    acc[i] = 0;
  endtask

  // Predict outputs after the next rising edge from current inputs.
  task automatic mstep(input int i);
    logic [63:0] nv [8];
    logic [31:0] cur;
    logic bad;
    int r, w, b, nxt;
    bad = paddr[i] >= 8'd64;
    r = int'(paddr[i]) / 8;
    w = (int'(paddr[i]) % 8) / 4;
    cur = bad ? 32'h0 : mread(i, r, w);
    for (int k = 0; k < 8; k++) nv[k] = e_val[i][k];
    if (e_ready[i]) begin
      if (!e_err[i] && r < 8) begin
        for (int j = 0; j < 32; j++) begin
          b = w * 32 + j;
          if (pwrite[i]) begin
            if (pstrb[i][j/8]) begin
              if (rw_m[b]) nv[r][b] = pwdata[i][j];
              if (w1c_m[b] && pwdata[i][j]) nv[r][b] = 1'b0;
            end
          end else if (rc_m[b]) begin
            nv[r][b] = 1'b0;
          end
        end
      end
      e_ready[i] = 1'b0;
      e_rdata[i] = '0;
      e_err[i] = 1'b0;
      busy[i] = 1'b0;
    end else begin
      nxt = 0;
      if (!busy[i]) begin
        if (psel[i] && !penable[i]) nxt = 1;
      end else if (psel[i]) begin
        nxt = acc[i] + 1;
      end
      busy[i] = 1'b0;
      if (nxt != 0) begin
        if (nxt == wsof(i) + 1) begin
          e_ready[i] = 1'b1;
          e_rdata[i] = cur;
          e_err[i] = bad;
        end else begin
          busy[i] = 1'b1;
          acc[i] = nxt;
        end
      end
    end
    for (int k = 0; k < 8; k++)
      e_val[i][k] = nv[k] | (set_v[i][k] & (w1c_m | rc_m));
  endtask

  initial begin
    logic [15:0] fm;
    logic [1:0] md;
    fm = 16'hE4E4;
    for (int b = 0; b < 64; b++) begin
      md = fm[2*(b/8) +: 2];
      rw_m[b] = (md == 2'd0);
      ro_m[b] = (md == 2'd1);
      w1c_m[b] = (md == 2'd2);
      rc_m[b] = (md == 2'd3);
    end
    mreset(0);
    mreset(1);
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst[i]) mreset(i);
        chk($sformatf("d%0d pready", i), 64'(ready[i]),
            64'(e_ready[i]));
        chk($sformatf("d%0d prdata", i), 64'(prdata[i]),
            64'(e_rdata[i]));
        chk($sformatf("d%0d pslverr", i), 64'(slverr[i]),
            64'(e_err[i]));
        for (int r = 0; r < 8; r++)
          chk($sformatf("d%0d o_value[%0d]", i, r), ov[i][r],
              (e_val[i][r] & ~ro_m) | (ro_v[i][r] & ro_m));
        if (!rst[i]) mstep(i);
      end
    end
  end

  // ---------------- driver ----------------
  // Entered and left at posedge+1; drop>0 releases psel in that
  // access cycle. cyc is the access cycle that showed PREADY.
  task automatic xfer(input int i, input logic [7:0] a,
                      input logic wr, input logic [31:0] d,
                      input logic [3:0] s,
                      input logic [7:0][63:0] dset,
                      input int drop,
                      output logic [31:0] rd, output logic er,
                      output int cyc);
    psel[i] = 1'b1;
    penable[i] = 1'b0;
    pwrite[i] = wr;
    paddr[i] = a;
    pwdata[i] = d;
    pstrb[i] = s;
    cyc = 0;
    rd = '0;
    er = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      penable[i] = 1'b1;
      if (k == drop) begin
        psel[i] = 1'b0;
        penable[i] = 1'b0;
        return;
      end
      if (ready[i]) begin
        cyc = k;
        rd = prdata[i];
        er = slverr[i];
        set_v[i] = dset;
        @(posedge clk); #1;
        set_v[i] = '0;
        break;
      end
    end
    psel[i] = 1'b0;
    penable[i] = 1'b0;
  endtask

  task automatic pulse_set(input int i, input int r,
                           input logic [63:0] v);
    set_v[i][r] = v;
    @(posedge clk); #1;
    set_v[i] = '0;
  endtask

  logic [31:0] rd;
  logic er;
  int cyc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      psel[i] = 1'b0;
      penable[i] = 1'b0;
      pwrite[i] = 1'b0;
      paddr[i] = '0;
      pwdata[i] = '0;
      pstrb[i] = '0;
      ro_v[i] = '0;
      set_v[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    chk("reset pready", 64'(ready[0]), 64'h0);
    chk("reset value1", ov[0][1], 64'h0);

    // RW with a single strobe
    xfer(0, 8'h0C, 1'b1, 32'hA5A5A5A5, 4'b0001, '0, 0, rd, er, cyc);
    chk("rw latency", 64'(cyc), 64'd1);
    chk("rw value1", ov[0][1], 64'h000000A5_00000000);
    xfer(0, 8'h08, 1'b1, 32'h11223344, 4'hF, '0, 0, rd, er, cyc);
    chk("rw mixed", ov[0][1], 64'h000000A5_00000044);

    // W1C clear and set-beats-clear
    pulse_set(0, 2, 64'h00000000_00FF0000);
    xfer(0, 8'h10, 1'b1, 32'h000F0000, 4'hF, '0, 0, rd, er, cyc);
    chk("w1c clear", ov[0][2], 64'h00000000_00F00000);
    pulse_set(0, 2, 64'h00000000_00010000);
    set_v[0] = '0;
    begin
      logic [7:0][63:0] ds;
      ds = '0;
      ds[2] = 64'h00000000_00010000;
      xfer(0, 8'h10, 1'b1, 32'h000F0000, 4'hF, ds, 0,
           rd, er, cyc);
    end
    chk("w1c set wins", ov[0][2], 64'h00000000_00F10000);

    // RC read-then-clear
    pulse_set(0, 0, 64'h00000000_81000000);
    xfer(0, 8'h00, 1'b0, 32'h0, 4'h0, '0, 0, rd, er, cyc);
    chk("rc first read", 64'(rd), 64'h81000000);
    chk("rc cleared", ov[0][0], 64'h0);
    xfer(0, 8'h00, 1'b0, 32'h0, 4'h0, '0, 0, rd, er, cyc);
    chk("rc second read", 64'(rd), 64'h0);

    // RO
    ro_v[0][3][15:8] = 8'h5A;
    xfer(0, 8'h18, 1'b1, 32'hFFFFFFFF, 4'hF, '0, 0, rd, er, cyc);
    xfer(0, 8'h18, 1'b0, 32'h0, 4'h0, '0, 0, rd, er, cyc);
    chk("ro read", 64'(rd), 64'h00005AFF);

    // Error responses
    xfer(0, 8'h40, 1'b0, 32'h0, 4'h0, '0, 0, rd, er, cyc);
    chk("err read slverr", 64'(er), 64'h1);
    chk("err read data", 64'(rd), 64'h0);
    xfer(0, 8'h44, 1'b1, 32'hFFFFFFFF, 4'hF, '0, 0, rd, er, cyc);
    chk("err write slverr", 64'(er), 64'h1);
    chk("err write value1", ov[0][1], 64'h000000A5_00000044);
    chk("err write value3", ov[0][3], 64'h00000000_00005AFF);

    // Two wait states
    xfer(1, 8'h08, 1'b1, 32'hDEADBEEF, 4'hF, '0, 0, rd, er, cyc);
    chk("ws2 latency", 64'(cyc), 64'd3);
    chk("ws2 write", ov[1][1], 64'h00000000_000000EF);
    xfer(1, 8'h08, 1'b1, 32'h12345678, 4'hF, '0, 2, rd, er, cyc);
    repeat (3) @(posedge clk);
    #1;
    chk("ws2 abort", ov[1][1], 64'h00000000_000000EF);

    psel[1] = 1'b1;
    penable[1] = 1'b0;
    pwrite[1] = 1'b1;
    paddr[1] = 8'h0C;
    pwdata[1] = 32'hFF;
    pstrb[1] = 4'hF;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    #1;
    rst[1] = 1'b1;
    #1;
    chk("mid reset pready", 64'(ready[1]), 64'h0);
    chk("mid reset value1", ov[1][1], 64'h0);
    psel[1] = 1'b0;
    penable[1] = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst[1] = 1'b0;

    xfer(1, 8'h0C, 1'b1, 32'h000000AB, 4'b0001, '0, 0, rd, er, cyc);
    chk("ws2 after reset", ov[1][1], 64'h000000AB_00000000);
    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
